// File: rtl/lcd_pkg.sv
// Shared constants and state type for the LCD message arbiter.
// No ports; imported by lcd_rr_pick and lcd_msg_arbiter.
package lcd_pkg;

  localparam logic [7:0] LCD_NEWLINE = 8'h0A;
  localparam int LCD_COOLDOWN = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } lcd_arb_state_t;

endpackage

// File: rtl/lcd_rr_pick.sv
// Round-robin picker: first set bit of req scanning upward from ptr.
// Ports: req (requests), ptr (start index), pick (one-hot), idx (index).
module lcd_rr_pick
  import lcd_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic          found;
    logic [PW-1:0] j;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = j;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Round-robin message arbiter feeding one lcd_printer, with auto line wrap.
// Ports: req_valid/req_char/req_last/req_ready per source; char/print/busy
// to the printer; grant (one-hot owner) and active (message in flight).
module lcd_msg_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int LINE_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_char,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         char,
  output logic               print,
  input  logic               busy,
  output logic [N_REQ-1:0]   grant,
  output logic               active
);

  localparam int PW  = $clog2(N_REQ);
  localparam int CW  = $clog2(LINE_LEN + 1);
  localparam int CDW = $clog2(LCD_COOLDOWN + 1);

  lcd_arb_state_t state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    col_q, col_d;
  logic [CDW-1:0]   cd_q, cd_d;
  logic [7:0]       char_q, char_d;
  logic             print_q, print_d;

  logic [N_REQ-1:0][7:0] chars;
  logic [N_REQ-1:0]      pick;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         ptr_next;

  logic       g_valid;
  logic       g_last;
  logic [7:0] g_char;
  logic       streaming;
  logic       slot_ok;
  logic       wrap_hold;
  logic       take;
  logic       wrap_emit;

  assign chars = req_char;

  lcd_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign g_valid   = req_valid[gidx_q];
  assign g_last    = req_last[gidx_q];
  assign g_char    = chars[gidx_q];
  assign streaming = (state_q == ST_STREAM);

  // One print slot every 3 cycles, only while the printer has room.
  assign slot_ok = streaming && !busy && (cd_q == '0);

  // A full line holds the next printable byte until a newline is sent.
  assign wrap_hold = (col_q == CW'(LINE_LEN)) &&
                     (g_char != LCD_NEWLINE);

  assign take      = slot_ok && !wrap_hold && g_valid;
  assign wrap_emit = slot_ok && wrap_hold && g_valid;

  assign req_ready = (slot_ok && !wrap_hold) ? grant_q : '0;

  assign ptr_next = (gidx_q == PW'(N_REQ - 1)) ?
                    '0 : gidx_q + PW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    col_d    = col_q;
    cd_d     = (cd_q != '0) ? cd_q - CDW'(1) : '0;
    char_d   = char_q;
    print_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d = ST_STREAM;
          grant_d = pick;
          gidx_d  = pick_idx;
        end
      end
      ST_STREAM: begin
        unique case (1'b1)
          wrap_emit: begin
            print_d = 1'b1;
            char_d  = LCD_NEWLINE;
            col_d   = '0;
            cd_d    = CDW'(LCD_COOLDOWN);
          end
          take: begin
            print_d = 1'b1;
            char_d  = g_char;
            cd_d    = CDW'(LCD_COOLDOWN);
            // Non-printables still occupy a cell on the display.
            col_d   = (g_char == LCD_NEWLINE) ?
                      '0 : col_q + CW'(1);
            if (g_last) begin
              rr_ptr_d = ptr_next;
              grant_d  = '0;
              state_d  = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      col_q    <= '0;
      cd_q     <= '0;
      char_q   <= '0;
      print_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      col_q    <= col_d;
      cd_q     <= cd_d;
      char_q   <= char_d;
      print_q  <= print_d;
    end
  end

  assign char   = char_q;
  assign print  = print_q;
  assign grant  = grant_q;
  assign active = streaming;

endmodule
